// File: rtl/aclock_set_ctrl.sv
// rtl/aclock_set_ctrl.sv - button sequencer, time/alarm editor and snooze scheduler for aclock
//
// Purpose: turns single-cycle debounced button pulses into BCD edit values,
// one-cycle load strobes, stop pulses and the alarm-enable level for the
// aclock core, and gates the core's raw Alarm into the buzzer with snooze.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   btn_set_time/btn_set_alarm start editing clock time / alarm time
//   btn_inc, btn_next          increment field / advance hour->minute->commit
//   btn_al_toggle              toggle alarm enable (AL_ON)
//   btn_snooze, btn_stop       snooze / stop a sounding alarm
//   Alarm                      raw alarm from aclock
//   cur_H1..cur_M0             current time from aclock (BCD)
//   H_in1..M_in0               edit registers to aclock (BCD)
//   LD_time, LD_alarm          one-cycle load strobes
//   STOP_al                    one-cycle stop pulse to aclock
//   AL_ON                      alarm enable level
//   buzzer                     Alarm & AL_ON & ~snooze_active
//   edit_field                 0 none, 1 hours, 2 minutes
//
// Optional feature macro: ACLK_EDIT_TIMEOUT_EN (edit abort after TIMEOUT_CYC idle cycles).

`timescale 1ns/1ps

module aclock_set_ctrl #(
    parameter int SNOOZE_CYC  = 3000,
    parameter int MAX_SNOOZE  = 3,
    parameter int TIMEOUT_CYC = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set_time,
    input  logic       btn_set_alarm,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       btn_al_toggle,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    input  logic       Alarm,
    input  logic [1:0] cur_H1,
    input  logic [3:0] cur_H0,
    input  logic [3:0] cur_M1,
    input  logic [3:0] cur_M0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       AL_ON,
    output logic       buzzer,
    output logic [1:0] edit_field
);

    localparam int SCW = $clog2(SNOOZE_CYC + 1);
    localparam int NCW = $clog2(MAX_SNOOZE + 1);
    localparam logic [SCW-1:0] SNOOZE_LOAD = SCW'(SNOOZE_CYC);
    localparam logic [NCW-1:0] MAX_N       = NCW'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

    state_t state, state_nxt;

    logic       target_alarm, target_n;
    logic [1:0] sh_h1;
    logic [3:0] sh_h0, sh_m1, sh_m0;
    logic [1:0] h1_n;
    logic [3:0] h0_n, m1_n, m0_n;
    logic       ld_time_n, ld_alarm_n;
    logic [1:0] edit_field_n;

    logic           snooze_active, act_n;
    logic [SCW-1:0] snooze_cnt, cnt_n;
    logic [NCW-1:0] snooze_count, count_n;
    logic           alarm_q;
    logic           al_on_n, stop_req, al_off, snooze_ok, stop_al_n;
    logic           timeout;

    // BCD hour increment with 23 -> 00 wrap
    function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'd2 && u >= 4'd3) return 6'd0;
        else if (u >= 4'd9)         return {t + 2'd1, 4'd0};
        else                        return {t, u + 4'd1};
    endfunction

    // BCD minute increment with 59 -> 00 wrap, no carry out
    function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
        if (u >= 4'd9) begin
            if (t >= 4'd5) return 8'd0;
            else           return {t + 4'd1, 4'd0};
        end
        return {t, u + 4'd1};
    endfunction

`ifdef ACLK_EDIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYC);

    logic [TW-1:0] idle_cnt;
    logic          any_btn;
    logic          in_edit;

    assign any_btn = btn_set_time | btn_set_alarm | btn_inc | btn_next |
                     btn_al_toggle | btn_snooze | btn_stop;
    assign in_edit = (state == EDIT_H) || (state == EDIT_M);

    // Counter rests at 0 outside the edit states, so entry to EDIT_H starts from 0.
    always_ff @(posedge clk) begin
        if (reset || any_btn || !in_edit)
            idle_cnt <= '0;
        else if (idle_cnt != TIMEOUT_LIM)
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout = in_edit && (idle_cnt == TIMEOUT_LIM) && !any_btn;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (btn_set_time || btn_set_alarm) state_nxt = EDIT_H;
            EDIT_H: if (btn_next) state_nxt = EDIT_M;
                    else if (timeout) state_nxt = IDLE;
            EDIT_M: if (btn_next) state_nxt = COMMIT;
                    else if (timeout) state_nxt = IDLE;
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered edit outputs
    always_comb begin
        h1_n       = H_in1;
        h0_n       = H_in0;
        m1_n       = M_in1;
        m0_n       = M_in0;
        target_n   = target_alarm;
        ld_time_n  = 1'b0;
        ld_alarm_n = 1'b0;
        case (state)
            IDLE: begin
                if (btn_set_time) begin
                    {h1_n, h0_n, m1_n, m0_n} = {cur_H1, cur_H0, cur_M1, cur_M0};
                    target_n = 1'b0;
                end else if (btn_set_alarm) begin
                    {h1_n, h0_n, m1_n, m0_n} = {sh_h1, sh_h0, sh_m1, sh_m0};
                    target_n = 1'b1;
                end
            end
            EDIT_H: if (btn_inc) {h1_n, h0_n} = hour_inc(H_in1, H_in0);
            EDIT_M: begin
                if (btn_inc) {m1_n, m0_n} = min_inc(M_in1, M_in0);
                // strobe is registered so it lines up with the COMMIT cycle
                if (btn_next) begin
                    ld_time_n  = !target_alarm;
                    ld_alarm_n = target_alarm;
                end
            end
            default: ;
        endcase
        case (state_nxt)
            EDIT_H:  edit_field_n = 2'd1;
            EDIT_M:  edit_field_n = 2'd2;
            default: edit_field_n = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {H_in1, H_in0, M_in1, M_in0} <= '0;
            {sh_h1, sh_h0, sh_m1, sh_m0} <= '0;
            target_alarm <= 1'b0;
            LD_time      <= 1'b0;
            LD_alarm     <= 1'b0;
            edit_field   <= 2'd0;
        end else begin
            {H_in1, H_in0, M_in1, M_in0} <= {h1_n, h0_n, m1_n, m0_n};
            target_alarm <= target_n;
            LD_time      <= ld_time_n;
            LD_alarm     <= ld_alarm_n;
            edit_field   <= edit_field_n;
            if (state == COMMIT && target_alarm)
                {sh_h1, sh_h0, sh_m1, sh_m0} <= {H_in1, H_in0, M_in1, M_in0};
        end
    end

    // Alarm enable, stop and snooze scheduling
    assign stop_req  = btn_stop && (Alarm || snooze_active);
    assign al_off    = btn_al_toggle && AL_ON;
    assign snooze_ok = btn_snooze && Alarm && AL_ON && !snooze_active &&
                       (snooze_count < MAX_N) && !stop_req && !al_off;

    always_comb begin
        al_on_n   = AL_ON ^ btn_al_toggle;
        act_n     = snooze_active;
        cnt_n     = snooze_cnt;
        count_n   = snooze_count;
        stop_al_n = stop_req || al_off;
        // last counted cycle clears the mute, so buzzer is muted SNOOZE_CYC cycles
        if (snooze_active) begin
            if (snooze_cnt <= 1) begin
                act_n = 1'b0;
                cnt_n = '0;
            end else begin
                cnt_n = snooze_cnt - 1'b1;
            end
        end
        if (alarm_q && !Alarm && !snooze_active)
            count_n = '0;
        if (snooze_ok) begin
            act_n   = 1'b1;
            cnt_n   = SNOOZE_LOAD;
            count_n = snooze_count + 1'b1;
        end
        if (stop_req || al_off) begin
            act_n   = 1'b0;
            cnt_n   = '0;
            count_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            AL_ON         <= 1'b0;
            STOP_al       <= 1'b0;
            buzzer        <= 1'b0;
            snooze_active <= 1'b0;
            snooze_cnt    <= '0;
            snooze_count  <= '0;
            alarm_q       <= 1'b0;
        end else begin
            AL_ON         <= al_on_n;
            STOP_al       <= stop_al_n;
            buzzer        <= Alarm && al_on_n && !act_n;
            snooze_active <= act_n;
            snooze_cnt    <= cnt_n;
            snooze_count  <= count_n;
            alarm_q       <= Alarm;
        end
    end

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// tb/tb_aclock_set_ctrl.sv - self-checking bench for aclock_set_ctrl

`timescale 1ns/1ps

module tb_aclock_set_ctrl;

    localparam int SNZ  = 16;
    localparam int MAXS = 3;
    localparam int TOC  = 30;

    localparam logic [6:0] B_SET_T = 7'b0000001;
    localparam logic [6:0] B_SET_A = 7'b0000010;
    localparam logic [6:0] B_INC   = 7'b0000100;
    localparam logic [6:0] B_NEXT  = 7'b0001000;
    localparam logic [6:0] B_TOG   = 7'b0010000;
    localparam logic [6:0] B_SNZ   = 7'b0100000;
    localparam logic [6:0] B_STOP  = 7'b1000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] btn = '0;
    logic       Alarm = 1'b0;
    logic [1:0] cur_H1 = '0;
    logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, STOP_al, AL_ON, buzzer;
    logic [1:0] edit_field;

    aclock_set_ctrl #(.SNOOZE_CYC(SNZ), .MAX_SNOOZE(MAXS), .TIMEOUT_CYC(TOC)) dut (
        .clk(clk), .reset(reset),
        .btn_set_time(btn[0]), .btn_set_alarm(btn[1]), .btn_inc(btn[2]),
        .btn_next(btn[3]), .btn_al_toggle(btn[4]), .btn_snooze(btn[5]),
        .btn_stop(btn[6]), .Alarm(Alarm),
        .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
        .AL_ON(AL_ON), .buzzer(buzzer), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       alarm;
        logic [1:0] c_h1;
        logic [3:0] c_h0, c_m1, c_m0;
        int         hinc;
        int         minc;
        logic [1:0] e_h1;
        logic [3:0] e_h0, e_m1, e_m0;
    } vec_t;

    typedef struct {
        logic        alarm;
        logic [13:0] hm;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    int total = 0, passed = 0;
    int strobes = 0, expected_strobes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic press(input logic [6:0] b);
        @(negedge clk);
        btn = b;
        @(negedge clk);
        btn = '0;
    endtask

    // Scoreboard: every load strobe must match the oldest expected commit
    always @(negedge clk) begin
        if (!reset && (LD_time || LD_alarm)) begin
            strobes++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ld_target", {LD_alarm, LD_time}, e.alarm ? 2'b10 : 2'b01);
                check("ld_value", {H_in1, H_in0, M_in1, M_in0}, e.hm);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        {cur_H1, cur_H0, cur_M1, cur_M0} = {v.c_h1, v.c_h0, v.c_m1, v.c_m0};
        press(v.alarm ? B_SET_A : B_SET_T);
        check("edit_field_h", edit_field, 1);
        for (int i = 0; i < v.hinc; i++) press(B_INC);
        press(B_NEXT);
        check("edit_field_m", edit_field, 2);
        for (int i = 0; i < v.minc; i++) press(B_INC);
        check("edit_value", {H_in1, H_in0, M_in1, M_in0}, {v.e_h1, v.e_h0, v.e_m1, v.e_m0});
        e.alarm = v.alarm;
        e.hm    = {v.e_h1, v.e_h0, v.e_m1, v.e_m0};
        sb.push_back(e);
        expected_strobes++;
        press(B_NEXT);
        @(negedge clk);
        check("edit_field_idle", edit_field, 0);
        check("ld_low_after", {LD_time, LD_alarm}, 0);
    endtask

    task automatic snooze_len();
        int n;
        press(B_SNZ);
        check("snooze_mute", buzzer, 0);
        n = 1;
        for (int i = 0; i < SNZ + 10; i++) begin
            @(negedge clk);
            if (buzzer) break;
            n++;
        end
        check("snooze_len", n, SNZ);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        //           alarm cur_h1 h0    m1    m0    hi  mi  exp_h1 h0    m1    m0
        vecs[0] = '{1'b0, 2'd1, 4'd0, 4'd2, 4'd0,  1,  5, 2'd1, 4'd1, 4'd2, 4'd5};
        vecs[1] = '{1'b1, 2'd0, 4'd0, 4'd0, 4'd0, 23,  0, 2'd2, 4'd3, 4'd0, 4'd0};
        vecs[2] = '{1'b1, 2'd0, 4'd0, 4'd0, 4'd0,  0,  0, 2'd2, 4'd3, 4'd0, 4'd0};
        vecs[3] = '{1'b0, 2'd2, 4'd3, 4'd1, 4'd0,  1,  0, 2'd0, 4'd0, 4'd1, 4'd0};
        vecs[4] = '{1'b0, 2'd1, 4'd4, 4'd5, 4'd9,  0,  1, 2'd1, 4'd4, 4'd0, 4'd0};
        vecs[5] = '{1'b0, 2'd0, 4'd9, 4'd0, 4'd9,  1,  1, 2'd1, 4'd0, 4'd1, 4'd0};
        vecs[6] = '{1'b0, 2'd1, 4'd9, 4'd4, 4'd5,  1, 16, 2'd2, 4'd0, 4'd0, 4'd1};
        vecs[7] = '{1'b1, 2'd0, 4'd0, 4'd0, 4'd0,  2,  7, 2'd0, 4'd1, 4'd0, 4'd7};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_edit_regs", {H_in1, H_in0, M_in1, M_in0}, 0);
        check("reset_strobes", {LD_time, LD_alarm, STOP_al}, 0);
        check("reset_al_buzz", {AL_ON, buzzer}, 0);
        check("reset_edit_field", edit_field, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // set_time and set_alarm together: time wins, loads cur not shadow
        {cur_H1, cur_H0, cur_M1, cur_M0} = {2'd1, 4'd2, 4'd3, 4'd4};
        press(B_SET_T | B_SET_A);
        check("both_set_value", {H_in1, H_in0, M_in1, M_in0}, {2'd1, 4'd2, 4'd3, 4'd4});
        press(B_SET_A);
        check("set_ignored_in_edit", {H_in1, H_in0, M_in1, M_in0}, {2'd1, 4'd2, 4'd3, 4'd4});
        press(B_NEXT);
        e.alarm = 1'b0;
        e.hm    = {2'd1, 4'd2, 4'd3, 4'd4};
        sb.push_back(e);
        expected_strobes++;
        press(B_NEXT);
        @(negedge clk);

        // snooze scheduling
        press(B_TOG);
        check("al_on_set", AL_ON, 1);
        @(negedge clk);
        Alarm = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("buzzer_on", buzzer, 1);
        for (int k = 0; k < MAXS; k++) snooze_len();
        press(B_SNZ);
        check("snooze_over_limit", buzzer, 1);
        repeat (3) @(negedge clk);
        check("snooze_over_limit_hold", buzzer, 1);

        press(B_STOP);
        check("stop_pulse", STOP_al, 1);
        @(negedge clk);
        check("stop_pulse_end", STOP_al, 0);

        press(B_STOP | B_SNZ);
        check("stop_beats_snooze", STOP_al, 1);
        check("stop_beats_snooze_buz", buzzer, 1);
        @(negedge clk);
        check("stop_one_cycle", STOP_al, 0);
        check("no_snooze_started", buzzer, 1);

        press(B_SNZ);
        check("count_cleared_by_stop", buzzer, 0);

        press(B_TOG);
        check("al_off", AL_ON, 0);
        check("al_off_stop", STOP_al, 1);
        check("al_off_buzz", buzzer, 0);
        Alarm = 1'b0;
        @(negedge clk);

        // reset inside EDIT_M: no strobe, registers cleared
        {cur_H1, cur_H0, cur_M1, cur_M0} = {2'd0, 4'd5, 4'd0, 4'd6};
        press(B_SET_T);
        press(B_NEXT);
        check("pre_reset_field", edit_field, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_field", edit_field, 0);
        check("mid_reset_regs", {H_in1, H_in0, M_in1, M_in0}, 0);
        check("mid_reset_ld", {LD_time, LD_alarm}, 0);
        repeat (5) @(negedge clk);

`ifdef ACLK_EDIT_TIMEOUT_EN
        press(B_SET_T);
        check("timeout_entry", edit_field, 1);
        repeat (TOC + 5) @(negedge clk);
        check("timeout_exit", edit_field, 0);
        repeat (3) @(negedge clk);
`endif

        check("sb_empty", sb.size(), 0);
        check("strobe_count", strobes, expected_strobes);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
